// File: rtl/pong_ball.sv
// Ball motion and collision engine for FPGA-Pong: moves a square ball once per animation
// strobe, bounces off walls and the paddle top, detects bottom misses and counts hits.
// Optional BALL_SPEEDUP_EN: every 4th paddle hit raises the speed, and a serve restores it.
module pong_ball #(
    parameter int H_SIZE       = 8,
    parameter int IX           = 320,
    parameter int IY           = 120,
    parameter int D_WIDTH      = 640,
    parameter int D_HEIGHT     = 480,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic [11:0] i_pad_x1,
    input  logic [11:0] i_pad_x2,
    input  logic [11:0] i_pad_y1,
    input  logic [11:0] i_pad_y2,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [1:0]  o_state,
    output logic        o_hit,
    output logic        o_miss,
    output logic [7:0]  o_score
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [12:0] H13     = 13'(H_SIZE);
    localparam logic [12:0] XMAX13  = 13'(D_WIDTH - 1);
    localparam logic [12:0] YMAX13  = 13'(D_HEIGHT - 1);
    localparam logic [11:0] XRIGHT  = 12'(D_WIDTH - 1 - H_SIZE);
    localparam logic [11:0] HS12    = 12'(H_SIZE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d;   // 1 = moving right
    logic               dy_q, dy_d;   // 1 = moving down
    logic [7:0]         score_q, score_d;
    logic               hit_q, hit_d, miss_q, miss_d;
    logic [2:0]         spd;

`ifdef BALL_SPEEDUP_EN
    logic [2:0]         speed_q, speed_d;
    assign spd = speed_q;
`else
    assign spd = 3'(SPEED);
`endif

    // Paddle bottom edge is part of the shared edge interface but plays no role in collision.
    logic unused_pad_y2;
    assign unused_pad_y2 = ^i_pad_y2;

    logic        upd;
    logic [12:0] x13, y13, spd13, pad_x1_13, pad_x2_13, pad_y1_13;
    logic        hit_wall_r, hit_wall_l, hit_top, hit_pad, hit_bottom;

    assign upd       = i_ani_stb && i_animate;
    assign x13       = {1'b0, x_q};
    assign y13       = {1'b0, y_q};
    assign spd13     = 13'(spd);
    assign pad_x1_13 = {1'b0, i_pad_x1};
    assign pad_x2_13 = {1'b0, i_pad_x2};
    assign pad_y1_13 = {1'b0, i_pad_y1};

    // Left-side tests are rearranged as additions so nothing ever underflows.
    assign hit_wall_r = dx_q  && (x13 + H13 + spd13 >= XMAX13);
    assign hit_wall_l = !dx_q && (x13 < H13 + spd13);
    assign hit_top    = !dy_q && (y13 < H13 + spd13);
    assign hit_pad    = dy_q && (y13 + H13 <= pad_y1_13) && (y13 + H13 + spd13 >= pad_y1_13)
                        && (x13 + H13 >= pad_x1_13) && (x13 <= pad_x2_13 + H13);
    assign hit_bottom = dy_q && (y13 + H13 + spd13 >= YMAX13);

    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        score_d = score_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
`ifdef BALL_SPEEDUP_EN
        speed_d = speed_q;
`endif
        if (upd) begin
            unique case (state_q)
                ST_SERVE: begin
                    x_d = 12'(IX);
                    y_d = 12'(IY);
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                        dy_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (hit_wall_r) begin
                        x_d  = XRIGHT;
                        dx_d = 1'b0;
                    end else if (hit_wall_l) begin
                        x_d  = HS12;
                        dx_d = 1'b1;
                    end else if (dx_q) begin
                        x_d = x_q + 12'(spd);
                    end else begin
                        x_d = x_q - 12'(spd);
                    end

                    if (hit_top) begin
                        y_d  = HS12;
                        dy_d = 1'b1;
                    end else if (hit_pad) begin
                        y_d   = i_pad_y1 - HS12 - 12'd1;
                        dy_d  = 1'b0;
                        hit_d = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
`ifdef BALL_SPEEDUP_EN
                        if (score_q[1:0] == 2'd3 && speed_q != 3'd7) speed_d = speed_q + 3'd1;
`endif
                    end else if (hit_bottom) begin
                        state_d = ST_MISS;
                        miss_d  = 1'b1;
                        x_d     = x_q;
                        y_d     = y_q;
                        dx_d    = dx_q;
                    end else if (dy_q) begin
                        y_d = y_q + 12'(spd);
                    end else begin
                        y_d = y_q - 12'(spd);
                    end
                end
                ST_MISS: begin
                    if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SERVE;
                        x_d     = 12'(IX);
                        y_d     = 12'(IY);
                        dx_d    = !dx_q;
`ifdef BALL_SPEEDUP_EN
                        speed_d = 3'(SPEED);
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_SERVE;
            cnt_q   <= '0;
            x_q     <= 12'(IX);
            y_q     <= 12'(IY);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            score_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_q <= 3'(SPEED);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            score_q <= score_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
`ifdef BALL_SPEEDUP_EN
            speed_q <= speed_d;
`endif
        end
    end

    assign o_x1    = x_q - HS12;
    assign o_x2    = x_q + HS12;
    assign o_y1    = y_q - HS12;
    assign o_y2    = y_q + HS12;
    assign o_state = state_q;
    assign o_hit   = hit_q;
    assign o_miss  = miss_q;
    assign o_score = score_q;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: serve, wall/top bounces, paddle hit, miss, re-serve,
// animate gating and asynchronous reset, all with hand-computed positions.
module tb_pong_ball;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b1;
    logic [11:0] i_pad_x1 = 12'd0;
    logic [11:0] i_pad_x2 = 12'd639;
    logic [11:0] i_pad_y1 = 12'd450;
    logic [11:0] i_pad_y2 = 12'd458;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic [1:0]  o_state;
    logic        o_hit, o_miss;
    logic [7:0]  o_score;

    int checks = 0;
    int errors = 0;

    pong_ball dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ani_stb(i_ani_stb),
        .i_animate(i_animate),
        .i_pad_x1 (i_pad_x1),
        .i_pad_x2 (i_pad_x2),
        .i_pad_y1 (i_pad_y1),
        .i_pad_y2 (i_pad_y2),
        .o_x1     (o_x1),
        .o_x2     (o_x2),
        .o_y1     (o_y1),
        .o_y2     (o_y2),
        .o_state  (o_state),
        .o_hit    (o_hit),
        .o_miss   (o_miss),
        .o_score  (o_score)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe every 4 clocks; returns at the falling edge right after the update edge.
    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge i_clk);
            i_ani_stb = 1'b1;
            @(negedge i_clk);
            i_ani_stb = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        check("rst_state", o_state, 0);
        check("rst_x1", o_x1, 312);
        check("rst_x2", o_x2, 328);
        check("rst_y1", o_y1, 112);
        check("rst_y2", o_y2, 128);
        check("rst_score", o_score, 0);
        check("rst_hit", o_hit, 0);
        check("rst_miss", o_miss, 0);
        i_rst = 1'b0;

        strobes(59);
        check("serve59_state", o_state, 0);
        check("serve59_x1", o_x1, 312);
        strobes(1);
        check("launch_state", o_state, 1);
        check("launch_x1", o_x1, 312);
        strobes(1);                         // PLAY update 1: x=322, y=122
        check("play1_x1", o_x1, 314);
        check("play1_y1", o_y1, 114);

        strobes(154);                       // update 155: x=630
        check("pre_wall_x2", o_x2, 638);
        strobes(1);                         // update 156: clamp x=631, turn left
        check("wall_r_x1", o_x1, 623);
        check("wall_r_x2", o_x2, 639);
        strobes(1);                         // update 157: x=629
        check("after_wall_x1", o_x1, 621);

        strobes(3);                         // update 160: y=440
        check("pre_hit_y2", o_y2, 448);
        check("pre_hit_pulse", o_hit, 0);
        strobes(1);                         // update 161: paddle hit, y=441
        check("hit_pulse", o_hit, 1);
        check("hit_y1", o_y1, 433);
        check("hit_y2", o_y2, 449);
        check("hit_score", o_score, 1);
        check("hit_x1", o_x1, 613);
        @(negedge i_clk);
        check("hit_clear", o_hit, 0);

        strobes(216);                       // update 377: y=9
        check("pre_top_y1", o_y1, 1);
        strobes(1);                         // update 378: clamp y=8, turn down
        check("top_y1", o_y1, 0);
        check("top_y2", o_y2, 16);
        strobes(1);                         // update 379: y=10
        check("after_top_y1", o_y1, 2);

        i_pad_x1 = 12'd700;                 // paddle out of the ball's horizontal reach
        i_pad_x2 = 12'd800;
        strobes(88);                        // update 467: x=9
        check("pre_wall_l_x1", o_x1, 1);
        strobes(1);                         // update 468: clamp x=8, turn right
        check("wall_l_x1", o_x1, 0);
        strobes(1);
        check("after_wall_l_x1", o_x1, 2);

        strobes(140);                       // update 609: y=470, x=290
        check("pre_miss_y2", o_y2, 478);
        check("pre_miss_state", o_state, 1);
        check("pre_miss_pulse", o_miss, 0);
        strobes(1);                         // update 610: miss, ball frozen
        check("miss_pulse", o_miss, 1);
        check("miss_state", o_state, 2);
        check("miss_y2", o_y2, 478);
        check("miss_x1", o_x1, 282);
        check("miss_no_hit", o_hit, 0);
        @(negedge i_clk);
        check("miss_clear", o_miss, 0);

        strobes(29);
        check("miss29_state", o_state, 2);
        check("miss29_y2", o_y2, 478);
        strobes(1);
        check("reserve_state", o_state, 0);
        check("reserve_x1", o_x1, 312);
        check("reserve_y1", o_y1, 112);
        check("reserve_score", o_score, 1);

        strobes(60);
        check("relaunch_state", o_state, 1);
        strobes(1);                         // dx was toggled: x=318
        check("relaunch_x1", o_x1, 310);
        check("relaunch_y1", o_y1, 114);

        i_animate = 1'b0;
        strobes(100);
        check("frozen_x1", o_x1, 310);
        check("frozen_y1", o_y1, 114);
        check("frozen_state", o_state, 1);
        check("frozen_score", o_score, 1);
        i_animate = 1'b1;

        #2 i_rst = 1'b1;
        #1;
        check("async_state", o_state, 0);
        check("async_score", o_score, 0);
        check("async_x1", o_x1, 312);
        check("async_y1", o_y1, 112);
        @(negedge i_clk);
        i_rst = 1'b0;
        strobes(1);
        check("post_rst_state", o_state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
